// File: rtl/softmax_job_scheduler.sv
// Job scheduler for a single softmax_core: queues row-depth commands, issues start
// pulses, watches core busy, and shares the BRAM fairly between the core and the host.
module softmax_job_scheduler #(
    parameter int QDEPTH        = 4,
    parameter int CNT_W         = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [7:0]                i_cmd_depth,
    output logic                      o_core_start,
    output logic [7:0]                o_core_depth,
    input  logic                      i_core_busy,
    input  logic                      i_host_req,
    output logic                      o_host_gnt,
    output logic                      o_done,
    output logic [CNT_W-1:0]          o_done_count,
    output logic [$clog2(QDEPTH):0]   o_q_level,
    output logic                      o_err_zero,
    output logic                      o_err_timeout,
    input  logic                      i_err_clr
);

    localparam int AW    = $clog2(QDEPTH);
    localparam int LVL_W = AW + 1;
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_HOST, S_START, S_WAIT, S_RUN} state_t;

    state_t             state_q;
    logic [7:0]         mem_q [QDEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [TO_W-1:0]    to_cnt_q;
    logic               last_host_q;
    logic               ready_q, start_q, gnt_q, done_q, err_zero_q, err_to_q;
    logic [7:0]         depth_q;
    logic [CNT_W-1:0]   done_cnt_q;

    logic push, store, zero_cmd, pop, timeout_hit;

    assign push        = i_en && i_cmd_valid && ready_q;
    assign store       = push && (i_cmd_depth != '0);
    assign zero_cmd    = push && (i_cmd_depth == '0);
    assign pop         = i_en && (state_q == S_START);
    assign timeout_hit = i_en && (state_q == S_WAIT) && !i_core_busy
                         && (to_cnt_q == TO_W'(START_TIMEOUT - 1));

    always_comb begin
        level_d = level_q;
        if (store && !pop)
            level_d = level_q + 1'b1;
        else if (!store && pop)
            level_d = level_q - 1'b1;
    end

    // Payload storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge i_clk) begin
        if (store)
            mem_q[wr_q] <= i_cmd_depth;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            to_cnt_q    <= '0;
            last_host_q <= 1'b0;
            ready_q     <= 1'b1;
            start_q     <= 1'b0;
            gnt_q       <= 1'b0;
            done_q      <= 1'b0;
            err_zero_q  <= 1'b0;
            err_to_q    <= 1'b0;
            depth_q     <= '0;
            done_cnt_q  <= '0;
        end else if (!i_en) begin
            ready_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (level_d < LVL_W'(QDEPTH));
            start_q <= 1'b0;
            done_q  <= 1'b0;
            level_q <= level_d;
            if (store)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;

            if (zero_cmd)
                err_zero_q <= 1'b1;
            else if (i_err_clr)
                err_zero_q <= 1'b0;
            if (timeout_hit)
                err_to_q <= 1'b1;
            else if (i_err_clr)
                err_to_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // A waiting job yields to the host unless the host had the last turn.
                    if (level_q != '0 && (!i_host_req || last_host_q)) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                        depth_q <= mem_q[rd_q];
                    end else if (i_host_req) begin
                        state_q <= S_HOST;
                        gnt_q   <= 1'b1;
                    end
                end
                S_HOST: begin
                    if (!i_host_req) begin
                        state_q     <= S_IDLE;
                        gnt_q       <= 1'b0;
                        last_host_q <= 1'b1;
                    end
                end
                S_START: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_core_busy) begin
                        state_q <= S_RUN;
                    end else if (timeout_hit) begin
                        state_q     <= S_IDLE;
                        last_host_q <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!i_core_busy) begin
                        state_q     <= S_IDLE;
                        done_q      <= 1'b1;
                        done_cnt_q  <= done_cnt_q + 1'b1;
                        last_host_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready   = ready_q;
    assign o_core_start  = start_q;
    assign o_core_depth  = depth_q;
    assign o_host_gnt    = gnt_q;
    assign o_done        = done_q;
    assign o_done_count  = done_cnt_q;
    assign o_q_level     = level_q;
    assign o_err_zero    = err_zero_q;
    assign o_err_timeout = err_to_q;

endmodule

// File: tb/tb_softmax_job_scheduler.sv
// Directed bench for softmax_job_scheduler with a depth scoreboard checked at each core start.
module tb_softmax_job_scheduler;

    localparam int QDEPTH = 4;
    localparam int CNT_W  = 16;
    localparam int TMO    = 8;

    logic                    i_clk = 1'b0;
    logic                    i_rst, i_en, i_cmd_valid, i_core_busy, i_host_req, i_err_clr;
    logic [7:0]              i_cmd_depth;
    logic                    o_cmd_ready, o_core_start, o_host_gnt, o_done;
    logic [7:0]              o_core_depth;
    logic [CNT_W-1:0]        o_done_count;
    logic [$clog2(QDEPTH):0] o_q_level;
    logic                    o_err_zero, o_err_timeout;

    int total = 0;
    int bad   = 0;
    int sb[$];

    softmax_job_scheduler #(.QDEPTH(QDEPTH), .CNT_W(CNT_W), .START_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_depth(i_cmd_depth),
        .o_core_start(o_core_start), .o_core_depth(o_core_depth), .i_core_busy(i_core_busy),
        .i_host_req(i_host_req), .o_host_gnt(o_host_gnt),
        .o_done(o_done), .o_done_count(o_done_count), .o_q_level(o_q_level),
        .o_err_zero(o_err_zero), .o_err_timeout(o_err_timeout), .i_err_clr(i_err_clr)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] d);
        i_cmd_valid = 1'b1;
        i_cmd_depth = d;
        if (d != 8'd0) sb.push_back(int'(d));
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic expect_start(input string tag);
        int exp;
        for (int i = 0; i < 20; i++) begin
            if (o_core_start) break;
            step();
        end
        chk({tag, "_start"}, 32'(o_core_start), 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : -1;
        chk({tag, "_depth"}, 32'(o_core_depth), exp);
        chk({tag, "_nognt"}, 32'(o_host_gnt), 32'd0);
    endtask

    task automatic run_job(input string tag);
        expect_start(tag);
        i_core_busy = 1'b1;
        step();
        step();
        i_core_busy = 1'b0;
        step();
        chk({tag, "_done"}, 32'(o_done), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(o_cmd_ready),   32'd1);
        chk({tag, "_start"}, 32'(o_core_start),  32'd0);
        chk({tag, "_depth"}, 32'(o_core_depth),  32'd0);
        chk({tag, "_gnt"},   32'(o_host_gnt),    32'd0);
        chk({tag, "_done"},  32'(o_done),        32'd0);
        chk({tag, "_cnt"},   32'(o_done_count),  32'd0);
        chk({tag, "_lvl"},   32'(o_q_level),     32'd0);
        chk({tag, "_ezero"}, 32'(o_err_zero),    32'd0);
        chk({tag, "_etmo"},  32'(o_err_timeout), 32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_cmd_valid = 1'b0; i_cmd_depth = '0;
        i_core_busy = 1'b0; i_host_req = 1'b0; i_err_clr = 1'b0;
        step();
        step();
        chk_reset_state("rst");
        i_rst = 1'b0;

        // Single job: start two cycles after the push, then run to completion
        push_cmd(8'd5);
        chk("t1_lvl", 32'(o_q_level), 32'd1);
        chk("t1_nostart", 32'(o_core_start), 32'd0);
        step();
        chk("t1_lat", 32'(o_core_start), 32'd1);
        expect_start("t1");
        step();
        chk("t1_pulse", 32'(o_core_start), 32'd0);
        chk("t1_pop", 32'(o_q_level), 32'd0);
        i_core_busy = 1'b1;
        repeat (10) step();
        i_core_busy = 1'b0;
        step();
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_cnt", 32'(o_done_count), 32'd1);
        step();
        chk("t1_done_off", 32'(o_done), 32'd0);

        // FIFO fill while the core is busy; fifth push dropped
        push_cmd(8'd9);
        expect_start("t2a");
        i_core_busy = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            i_cmd_valid = 1'b1;
            i_cmd_depth = 8'(11 + i);
            if (i < 4) sb.push_back(11 + i);
            step();
            if (i == 2) chk("t2_ready3", 32'(o_cmd_ready), 32'd1);
            if (i == 3) chk("t2_full", 32'(o_cmd_ready), 32'd0);
        end
        i_cmd_valid = 1'b0;
        chk("t2_lvl", 32'(o_q_level), 32'd4);
        chk("t2_noerr", 32'(o_err_zero), 32'd0);
        i_core_busy = 1'b0;
        step();
        chk("t2_cnt_a", 32'(o_done_count), 32'd2);
        run_job("t2b");
        run_job("t2c");
        run_job("t2d");
        run_job("t2e");
        chk("t2_cnt", 32'(o_done_count), 32'd6);
        chk("t2_empty", 32'(o_q_level), 32'd0);

        // Fairness between host and queued jobs
        i_host_req = 1'b1;
        push_cmd(8'd21);
        chk("t3_gnt1", 32'(o_host_gnt), 32'd1);
        push_cmd(8'd22);
        repeat (3) step();
        chk("t3_lvl", 32'(o_q_level), 32'd2);
        chk("t3_hold_gnt", 32'(o_host_gnt), 32'd1);
        chk("t3_nostart", 32'(o_core_start), 32'd0);
        i_host_req = 1'b0;
        step();
        chk("t3_rel", 32'(o_host_gnt), 32'd0);
        i_host_req = 1'b1;
        run_job("t3j1");
        step();
        chk("t3_gnt2", 32'(o_host_gnt), 32'd1);
        chk("t3_wait_job", 32'(o_core_start), 32'd0);
        i_host_req = 1'b0;
        step();
        chk("t3_rel2", 32'(o_host_gnt), 32'd0);
        run_job("t3j2");
        chk("t3_cnt", 32'(o_done_count), 32'd8);

        // Zero-depth command and error clear
        push_cmd(8'd0);
        chk("t4_ezero", 32'(o_err_zero), 32'd1);
        chk("t4_lvl", 32'(o_q_level), 32'd0);
        repeat (3) step();
        chk("t4_nostart", 32'(o_core_start), 32'd0);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("t4_clr", 32'(o_err_zero), 32'd0);
        i_err_clr = 1'b1;
        push_cmd(8'd0);
        i_err_clr = 1'b0;
        chk("t4_setwins", 32'(o_err_zero), 32'd1);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;

        // Start timeout, then the next queued job runs normally
        push_cmd(8'd31);
        push_cmd(8'd32);
        expect_start("t5a");
        step();
        repeat (TMO - 1) step();
        chk("t5_notyet", 32'(o_err_timeout), 32'd0);
        step();
        chk("t5_etmo", 32'(o_err_timeout), 32'd1);
        chk("t5_nodone", 32'(o_done), 32'd0);
        chk("t5_cnt", 32'(o_done_count), 32'd8);
        run_job("t5b");
        chk("t5_cnt2", 32'(o_done_count), 32'd9);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("t5_clr", 32'(o_err_timeout), 32'd0);

        // Enable freeze during RUN
        push_cmd(8'd41);
        expect_start("t6");
        i_core_busy = 1'b1;
        step();
        step();
        i_en = 1'b0;
        i_core_busy = 1'b0;
        step();
        step();
        chk("t6_frz_done", 32'(o_done), 32'd0);
        chk("t6_frz_cnt", 32'(o_done_count), 32'd9);
        chk("t6_frz_ready", 32'(o_cmd_ready), 32'd0);
        i_en = 1'b1;
        step();
        chk("t6_done", 32'(o_done), 32'd1);
        chk("t6_cnt", 32'(o_done_count), 32'd10);

        // Reset in the middle of a job
        push_cmd(8'd0);
        push_cmd(8'd51);
        expect_start("t7");
        i_core_busy = 1'b1;
        step();
        step();
        i_rst = 1'b1;
        step();
        chk_reset_state("t7rst");
        i_rst = 1'b0;
        i_core_busy = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmax_job_scheduler.md
Name: softmax_job_scheduler

Overview:
Sequences multiple softmax jobs onto a single softmax_core instance and arbitrates ownership of the shared BRAM between the core and the external host.
- Accepts job commands (row depth) into a small FIFO.
- Issues one-cycle start pulses to the core and tracks core busy.
- Grants the host BRAM access only while the core is idle, alternating fairly with queued jobs.
- Sits between the system controller/CPU and softmax_core.

Parameters:
QDEPTH, 4, job FIFO entries (power of two, >=2)
CNT_W, 16, width of completed-job counter
START_TIMEOUT, 8, max cycles to wait for core busy after start (>=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_en  in  1  global enable; low = freeze all state
i_cmd_valid  in  1  job command valid
o_cmd_ready  out  1  FIFO can accept command
i_cmd_depth  in  8  job row depth
o_core_start  out  1  one-cycle start to softmax_core
o_core_depth  out  8  depth for softmax_core, held between starts
i_core_busy  in  1  softmax_core busy
i_host_req  in  1  host requests BRAM access
o_host_gnt  out  1  host owns BRAM (core idle, no start pending)
o_done  out  1  one-cycle pulse per completed job
o_done_count  out  CNT_W  completed jobs, wraps
o_q_level  out  $clog2(QDEPTH)+1  FIFO occupancy
o_err_zero  out  1  sticky: zero-depth command dropped
o_err_timeout  out  1  sticky: core never asserted busy
i_err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (synchronous, active-high, i_rst wins over i_en):
  - All outputs 0 except o_cmd_ready=1.
  - FSM=IDLE, FIFO empty, last_owner=CORE.
- i_en=0: FSM, FIFO, counters and errors frozen; o_core_start, o_done and o_cmd_ready forced 0; o_host_gnt holds its value.
- FIFO:
  - Push on i_cmd_valid && o_cmd_ready.
  - o_cmd_ready = (level < QDEPTH).
  - Push with i_cmd_depth==0 completes the handshake, is not stored, and sets o_err_zero.
  - Pop occurs in START. Simultaneous push and pop leaves level unchanged.
  - A push when full is ignored with no error.
- FSM states:
  - IDLE:
    - If level>0 and (!i_host_req or last_owner==HOST) -> START.
    - Else if i_host_req -> HOST.
    - Else stay.
  - HOST:
    - o_host_gnt=1 (registered; asserts the cycle after entry).
    - When i_host_req=0 -> IDLE, last_owner=HOST, o_host_gnt=0 the next cycle.
    - Queued jobs wait; no preemption.
  - START:
    - o_core_start=1 for exactly one cycle; o_core_depth<=FIFO head; pop.
    - Timeout counter cleared; -> WAIT_BUSY.
  - WAIT_BUSY:
    - i_core_busy=1 -> RUN.
    - Else counter++; at START_TIMEOUT cycles -> IDLE, o_err_timeout=1, last_owner=CORE, no o_done, o_done_count unchanged.
  - RUN: i_core_busy=0 -> IDLE, o_done=1 one cycle, o_done_count++ (wraps at 2^CNT_W), last_owner=CORE.
- Fairness: after any job completes, a waiting host is served next; after the host releases, one queued job runs before the host is granted again.
- o_host_gnt is never 1 in START, WAIT_BUSY or RUN. Host access and core start are mutually exclusive.
- i_err_clr in the same cycle as an error-setting event: the set wins.
- Reset mid-job: the scheduler returns to IDLE immediately. The core is reset by the same i_rst.
- All outputs are registered. Command-to-start latency is 2 cycles (push, IDLE->START) when idle and no host request is pending.

Test Plan:
- Reset, then push depth=5 with host idle -> o_core_start at cycle 2 after push, o_core_depth=5. Drive busy 1 for 10 cycles then 0 -> o_done pulse, o_done_count=1.
- Push 5 commands with QDEPTH=4 and core held busy -> o_cmd_ready=0 after the 4th; 5th dropped; o_q_level=4. Jobs start in push order with depths preserved.
- Host holds i_host_req while 2 jobs are queued, last_owner=CORE -> host granted first. On release, one job runs. With host re-requesting, the host is granted before the second job.
- Push depth=0 -> o_err_zero=1, o_q_level stays 0, no start. Then i_err_clr -> o_err_zero=0.
- Start a job with busy never asserted -> after 8 WAIT_BUSY cycles, o_err_timeout=1, FSM back in IDLE, o_done_count unchanged. The next queued job starts normally.
- i_en=0 during RUN while busy falls -> no o_done. Re-enable with busy=0 -> o_done the next cycle. Assert i_rst mid-RUN -> all outputs return to reset values in one cycle.
